// File: rtl/sync_fifo_pkg.sv
// Shared widths and the little-endian byte-select helper for the word/byte FIFOs.
package sync_fifo_pkg;
  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BIDX_W         = 2;

  function automatic logic [BYTE_W-1:0] byte_sel(input logic [WORD_W-1:0] word,
                                                 input logic [BIDX_W-1:0] idx);
    return word[{idx, 3'b000} +: BYTE_W];
  endfunction
endpackage

// File: rtl/sync_fifo_unpack_mem.sv
// DEPTH x 32 word storage: synchronous write port, asynchronous read port.
module sync_fifo_unpack_mem
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WORD_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WORD_W-1:0]        rdata_o
);
  logic [WORD_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/sync_fifo_unpack.sv
// 32-bit-in / 8-bit-out synchronous FIFO, bytes leave little-endian, 1-cycle read latency.
// Optional SYNC_FIFO_UNPACK_ERR_EN adds sticky overflow/underflow outputs.
module sync_fifo_unpack
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       wn,
  input  logic [WORD_W-1:0]          DATAIN,
  input  logic                       rn,
  output logic [BYTE_W-1:0]          DATAOUT,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH)+2:0]   level
`ifdef SYNC_FIFO_UNPACK_ERR_EN
  ,
  output logic                       overflow,
  output logic                       underflow
`endif
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [BIDX_W-1:0] bidx_q, bidx_d;
  logic [BYTE_W-1:0] dout_q, dout_d;
  logic [WORD_W-1:0] rd_word;
  logic              wr_acc, rd_acc, word_free;

  sync_fifo_unpack_mem #(.DEPTH(DEPTH)) u_mem (
    .clock   (clock),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (DATAIN),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_word)
  );

  // Flags come only from registered state, so same-cycle frees/fills never help the other side.
  assign level     = {cnt_q, 2'b00} - {{(ADDR_W+1){1'b0}}, bidx_q};
  assign full      = (cnt_q == (ADDR_W+1)'(DEPTH));
  assign empty     = (level == '0);
  assign wr_acc    = wn && !full;
  assign rd_acc    = rn && !empty;
  assign word_free = rd_acc && (bidx_q == BIDX_W'(BYTES_PER_WORD-1));
  assign DATAOUT   = dout_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    bidx_d   = bidx_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q + {{ADDR_W{1'b0}}, wr_acc} - {{ADDR_W{1'b0}}, word_free};
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) begin
      dout_d = byte_sel(rd_word, bidx_q);
      bidx_d = bidx_q + 1'b1;
    end
    if (word_free) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      bidx_q   <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      bidx_q   <= bidx_d;
      dout_q   <= dout_d;
    end
  end

`ifdef SYNC_FIFO_UNPACK_ERR_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wn && full)  ovf_q <= 1'b1;
      if (rn && empty) unf_q <= 1'b1;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = unf_q;
`endif
endmodule

// File: tb/tb_sync_fifo_unpack.sv
// Directed self-checking bench for sync_fifo_unpack (DEPTH=8).
module tb_sync_fifo_unpack;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wn    = 1'b0;
  logic [31:0] DATAIN = '0;
  logic        rn    = 1'b0;
  logic [7:0]  DATAOUT;
  logic        full, empty;
  logic [5:0]  level;
`ifdef SYNC_FIFO_UNPACK_ERR_EN
  logic        overflow, underflow;
`endif

  int checks = 0;
  int errors = 0;

  sync_fifo_unpack #(.DEPTH(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .wn      (wn),
    .DATAIN  (DATAIN),
    .rn      (rn),
    .DATAOUT (DATAOUT),
    .full    (full),
    .empty   (empty),
    .level   (level)
`ifdef SYNC_FIFO_UNPACK_ERR_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        w;
    logic [31:0] din;
    logic        r;
    logic [7:0]  exp_dout;
    logic [5:0]  exp_level;
    logic        exp_full;
    logic        exp_empty;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r_st, input logic w, input logic [31:0] d, input logic r);
    reset  = r_st;
    wn     = w;
    DATAIN = d;
    rn     = r;
    @(posedge clock);
    #1;
    reset = 1'b0; wn = 1'b0; rn = 1'b0;
  endtask

  function automatic logic [31:0] ramp_word(input int k);
    logic [31:0] w;
    w = 32'h03020100 + 32'h04040404 * k;
    return w;
  endfunction

  initial begin
    int got;
    int wk;
    int cyc;
    logic was_full, was_empty, wr_req;

    // reset, underflow attempts, one word out, simultaneous write+read on empty, reset mid-stream
    vecs[0]  = '{1, 0, 32'h0,        0, 8'h00, 6'd0, 0, 1};
    vecs[1]  = '{0, 0, 32'h0,        1, 8'h00, 6'd0, 0, 1};
    vecs[2]  = '{0, 0, 32'h0,        1, 8'h00, 6'd0, 0, 1};
    vecs[3]  = '{0, 1, 32'hDDCCBBAA, 0, 8'h00, 6'd4, 0, 0};
    vecs[4]  = '{0, 0, 32'h0,        1, 8'hAA, 6'd3, 0, 0};
    vecs[5]  = '{0, 0, 32'h0,        1, 8'hBB, 6'd2, 0, 0};
    vecs[6]  = '{0, 0, 32'h0,        1, 8'hCC, 6'd1, 0, 0};
    vecs[7]  = '{0, 0, 32'h0,        1, 8'hDD, 6'd0, 0, 1};
    vecs[8]  = '{0, 0, 32'h0,        1, 8'hDD, 6'd0, 0, 1};
    vecs[9]  = '{0, 1, 32'h11223344, 1, 8'hDD, 6'd4, 0, 0};
    vecs[10] = '{0, 0, 32'h0,        1, 8'h44, 6'd3, 0, 0};
    vecs[11] = '{0, 1, 32'h55667788, 0, 8'h44, 6'd7, 0, 0};
    vecs[12] = '{0, 0, 32'h0,        1, 8'h33, 6'd6, 0, 0};
    vecs[13] = '{1, 0, 32'h0,        0, 8'h00, 6'd0, 0, 1};
    vecs[14] = '{0, 1, 32'hA1B2C3D4, 0, 8'h00, 6'd4, 0, 0};
    vecs[15] = '{0, 0, 32'h0,        1, 8'hD4, 6'd3, 0, 0};

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rst, vecs[i].w, vecs[i].din, vecs[i].r);
      chk($sformatf("v%0d dout", i),  {24'h0, DATAOUT}, {24'h0, vecs[i].exp_dout});
      chk($sformatf("v%0d level", i), {26'h0, level},   {26'h0, vecs[i].exp_level});
      chk($sformatf("v%0d full", i),  {31'h0, full},    {31'h0, vecs[i].exp_full});
      chk($sformatf("v%0d empty", i), {31'h0, empty},   {31'h0, vecs[i].exp_empty});
`ifdef SYNC_FIFO_UNPACK_ERR_EN
      if (i == 2)  chk("underflow sticky", {31'h0, underflow}, 32'h1);
      if (i == 12) chk("underflow held",   {31'h0, underflow}, 32'h1);
      if (i == 13) chk("underflow cleared", {31'h0, underflow}, 32'h0);
`endif
    end

    // fill to full, dropped 9th write, full drain in order
    step(1, 0, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 1, ramp_word(k), 0);
    chk("fill full", {31'h0, full}, 32'h1);
    chk("fill level", {26'h0, level}, 32'd32);
    step(0, 1, 32'h12345678, 0);
    chk("drop full", {31'h0, full}, 32'h1);
    chk("drop level", {26'h0, level}, 32'd32);
`ifdef SYNC_FIFO_UNPACK_ERR_EN
    chk("overflow sticky", {31'h0, overflow}, 32'h1);
`endif
    for (int b = 0; b < 32; b++) begin
      step(0, 0, 0, 1);
      chk($sformatf("drain byte%0d", b), {24'h0, DATAOUT}, b);
    end
    chk("drain empty", {31'h0, empty}, 32'h1);

    // full with byte_idx=3, then write and read together
    step(1, 0, 0, 0);
    for (int k = 0; k < 8; k++) step(0, 1, ramp_word(k), 0);
    for (int b = 0; b < 3; b++) step(0, 0, 0, 1);
    chk("bidx3 level", {26'h0, level}, 32'd29);
    chk("bidx3 full", {31'h0, full}, 32'h1);
    step(0, 1, 32'h12345678, 1);
    chk("wr+rd dout", {24'h0, DATAOUT}, 32'h03);
    chk("wr+rd full", {31'h0, full}, 32'h0);
    chk("wr+rd level", {26'h0, level}, 32'd28);
    for (int b = 4; b < 32; b++) begin
      step(0, 0, 0, 1);
      chk($sformatf("rest byte%0d", b), {24'h0, DATAOUT}, b);
    end
    chk("rest empty", {31'h0, empty}, 32'h1);

    // streaming 20 words through the pointer wrap while reading continuously
    step(1, 0, 0, 0);
    got = 0; wk = 0; cyc = 0;
    while (got < 80 && cyc < 400) begin
      was_full  = full;
      was_empty = empty;
      wr_req    = (wk < 20);
      step(0, wr_req, wr_req ? ramp_word(wk) : 32'h0, 1);
      if (wr_req && !was_full) wk++;
      if (!was_empty) begin
        chk($sformatf("stream byte%0d", got), {24'h0, DATAOUT}, got);
        got++;
      end
      cyc++;
    end
    chk("stream count", got, 80);
    chk("stream empty", {31'h0, empty}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
